// File: rtl/bist_pkg.sv
// Shared types and helpers for the LFSR/MISR BIST engine: controller states,
// the generic Galois step and default feedback masks.
package bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } bist_state_e;

  localparam logic [3:0]  POLY_W4  = 4'hC;
  localparam logic [7:0]  POLY_W8  = 8'hB8;
  localparam logic [15:0] POLY_W16 = 16'hB400;
  localparam logic [31:0] POLY_W32 = 32'h8020_0003;

  // Operands are zero-extended to 64 bits; callers truncate back to their width.
  function automatic logic [63:0] galois_step(input logic [63:0] s, input logic [63:0] poly);
    return (s >> 1) ^ (s[0] ? poly : 64'd0);
  endfunction

  function automatic logic [63:0] default_poly(input int w);
    case (w)
      4:       return 64'(POLY_W4);
      8:       return 64'(POLY_W8);
      16:      return 64'(POLY_W16);
      32:      return 64'(POLY_W32);
      default: return 64'd0;
    endcase
  endfunction

endpackage

// File: rtl/bist_lfsr_misr_if.sv
// Bundle between the chip test controller (master) and the BIST engine (slave),
// including the CUT pattern/response path.
interface bist_lfsr_misr_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             START;
  logic             ABORT;
  logic [CNT_W-1:0] NPAT;
  logic [WIDTH-1:0] RESP_IN;
  logic [WIDTH-1:0] GOLDEN;
  logic [WIDTH-1:0] PATTERN;
  logic             PAT_VALID;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH-1:0] SIGNATURE;
  logic             PASS;

  modport master (
    output START, ABORT, NPAT, RESP_IN, GOLDEN,
    input  PATTERN, PAT_VALID, BUSY, DONE, SIGNATURE, PASS
  );

  modport slave (
    input  START, ABORT, NPAT, RESP_IN, GOLDEN,
    output PATTERN, PAT_VALID, BUSY, DONE, SIGNATURE, PASS
  );
endinterface

// File: rtl/bist_galois_reg.sv
// Galois shift register with load and enable; serves as the pattern LFSR
// (xor_in tied low) or as the response MISR (xor_in = CUT response).
module bist_galois_reg
  import bist_pkg::*;
#(
  parameter int               WIDTH   = 16,
  parameter logic [WIDTH-1:0] POLY    = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CK,
  input  logic             RSTN,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] xor_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_step;

  assign w_step = WIDTH'(galois_step(64'(r_q), 64'(POLY)));

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_q <= RST_VAL;
    end else if (load) begin
      r_q <= load_val;
    end else if (en) begin
      r_q <= w_step ^ xor_in;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/bist_lfsr_misr.sv
// BIST engine: applies NPAT LFSR patterns to a CUT, compacts its responses
// (arriving LAT cycles later) in a MISR and compares against a golden signature.
module bist_lfsr_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] POLY  = WIDTH'(default_poly(WIDTH)),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(1),
  parameter int               CNT_W = 16,
  parameter int               LAT   = 1
) (
  input  logic               CK,
  input  logic               RSTN,
  bist_lfsr_misr_if.slave    bus
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  bist_state_e      r_state;
  logic             r_pat_valid;
  logic             r_busy;
  logic             r_done;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_npat;
  logic [LAT-1:0]   r_vld;

  logic [LAT-1:0]   w_vld_nxt;
  logic             w_cap_en;
  logic             w_drained;
  logic             w_start;
  logic [WIDTH-1:0] w_lfsr;
  logic [WIDTH-1:0] w_misr;

  // Valid pipe tracks patterns in flight through the CUT; its tail gates the MISR.
  assign w_vld_nxt = LAT'({r_vld, r_pat_valid});
  assign w_cap_en  = r_vld[LAT-1];
  assign w_drained = (w_vld_nxt == '0);
  assign w_start   = bus.START && !bus.ABORT && (r_state == ST_IDLE || r_state == ST_DONE);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      r_state     <= ST_IDLE;
      r_pat_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_npat      <= '0;
      r_vld       <= '0;
    end else if (bus.ABORT) begin
      r_state     <= ST_IDLE;
      r_pat_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cnt       <= '0;
      r_vld       <= '0;
    end else begin
      r_vld <= w_vld_nxt;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.START) begin
            r_npat <= bus.NPAT;
            r_cnt  <= '0;
            if (bus.NPAT == '0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= ST_RUN;
              r_pat_valid <= 1'b1;
              r_busy      <= 1'b1;
              r_done      <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (r_cnt == r_npat - CNT_W'(1)) begin
            r_state     <= ST_DRAIN;
            r_pat_valid <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (w_drained) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // LFSR holds through an abort; the MISR is cleared by start or abort.
  bist_galois_reg #(
    .WIDTH   (WIDTH),
    .POLY    (POLY),
    .RST_VAL (SEED_EFF)
  ) u_lfsr (
    .CK       (CK),
    .RSTN     (RSTN),
    .load     (w_start),
    .load_val (SEED_EFF),
    .en       (r_pat_valid && !bus.ABORT),
    .xor_in   ('0),
    .q        (w_lfsr)
  );

  bist_galois_reg #(
    .WIDTH   (WIDTH),
    .POLY    (POLY),
    .RST_VAL ('0)
  ) u_misr (
    .CK       (CK),
    .RSTN     (RSTN),
    .load     (w_start || bus.ABORT),
    .load_val ('0),
    .en       (w_cap_en),
    .xor_in   (bus.RESP_IN),
    .q        (w_misr)
  );

  assign bus.PATTERN   = w_lfsr;
  assign bus.PAT_VALID = r_pat_valid;
  assign bus.BUSY      = r_busy;
  assign bus.DONE      = r_done;
  assign bus.SIGNATURE = w_misr;
  assign bus.PASS      = r_done && (w_misr == bus.GOLDEN);

endmodule

// File: tb/tb_bist_lfsr_misr.sv
// Directed bench for bist_lfsr_misr: a scoreboard of per-cycle expectations is
// built when each run starts and drained cycle by cycle against the DUT.
module tb_bist_lfsr_misr;

  logic CK   = 1'b0;
  logic RSTN = 1'b1;

  always #5 CK = ~CK;

  bist_lfsr_misr_if #(.WIDTH(4), .CNT_W(8)) b1 ();
  bist_lfsr_misr_if #(.WIDTH(4), .CNT_W(8)) b3 ();

  bist_lfsr_misr #(.WIDTH(4), .POLY(4'hC), .SEED(4'h1), .CNT_W(8), .LAT(1)) u1 (
    .CK(CK), .RSTN(RSTN), .bus(b1));
  bist_lfsr_misr #(.WIDTH(4), .POLY(4'hC), .SEED(4'h1), .CNT_W(8), .LAT(3)) u3 (
    .CK(CK), .RSTN(RSTN), .bus(b3));

  typedef struct {
    logic       pv;
    logic [3:0] pat;
    logic       busy;
    logic       done;
    logic [3:0] sig;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [3:0] pat_tab [15];

  function automatic logic [3:0] g(input logic [3:0] s);
    return {1'b0, s[3:1]} ^ (s[0] ? 4'hC : 4'h0);
  endfunction

  task automatic tick();
    @(posedge CK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic ab, input logic [7:0] n,
                       input logic [3:0] resp, input logic [3:0] gold);
    if (sel == 1) begin
      b1.START = st; b1.ABORT = ab; b1.NPAT = n; b1.RESP_IN = resp; b1.GOLDEN = gold;
    end else begin
      b3.START = st; b3.ABORT = ab; b3.NPAT = n; b3.RESP_IN = resp; b3.GOLDEN = gold;
    end
  endtask

  task automatic sample(input int sel, output exp_t o, output logic pass);
    if (sel == 1) begin
      o.pv = b1.PAT_VALID; o.pat = b1.PATTERN; o.busy = b1.BUSY;
      o.done = b1.DONE; o.sig = b1.SIGNATURE; pass = b1.PASS;
    end else begin
      o.pv = b3.PAT_VALID; o.pat = b3.PATTERN; o.busy = b3.BUSY;
      o.done = b3.DONE; o.sig = b3.SIGNATURE; pass = b3.PASS;
    end
  endtask

  // Cycle c counts from the first cycle after the START edge.
  task automatic plan(input int n, input int lat, input logic [3:0] resp, output logic [3:0] fin);
    int last;
    last = (n == 0) ? 1 : n + lat + 1;
    fin  = 4'h0;
    for (int c = 1; c <= last; c++) begin
      exp_t       e;
      logic [3:0] s;
      s      = 4'h0;
      e.pv   = (c <= n);
      e.pat  = 4'h0;
      if (c <= n) e.pat = pat_tab[c-1];
      e.busy = (n != 0) && (c <= n + lat);
      e.done = (c == last);
      for (int k = lat + 1; (k <= c - 1) && (k <= n + lat); k++) s = g(s) ^ resp;
      e.sig  = s;
      sb.push_back(e);
      fin = s;
    end
  endtask

  task automatic run(input int sel, input int n, input int lat, input logic [3:0] resp,
                     input logic [3:0] gold, input int poke, input string tag);
    exp_t       e;
    exp_t       o;
    logic       pass;
    logic [3:0] fin;
    int         c;
    sb.delete();
    plan(n, lat, resp, fin);
    drive(sel, 1'b1, 1'b0, 8'(n), resp, gold);
    tick();
    drive(sel, 1'b0, 1'b0, 8'(n), resp, gold);
    c = 1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      sample(sel, o, pass);
      chk($sformatf("%s.c%0d.pv", tag, c),   8'(o.pv),   8'(e.pv));
      chk($sformatf("%s.c%0d.busy", tag, c), 8'(o.busy), 8'(e.busy));
      chk($sformatf("%s.c%0d.done", tag, c), 8'(o.done), 8'(e.done));
      chk($sformatf("%s.c%0d.sig", tag, c),  8'(o.sig),  8'(e.sig));
      if (e.pv) chk($sformatf("%s.c%0d.pat", tag, c), 8'(o.pat), 8'(e.pat));
      if (c == poke) drive(sel, 1'b1, 1'b0, 8'd1, resp, gold);
      tick();
      if (c == poke) drive(sel, 1'b0, 1'b0, 8'(n), resp, gold);
      c++;
    end
    sample(sel, o, pass);
    chk($sformatf("%s.hold_done", tag), 8'(o.done), 8'd1);
    chk($sformatf("%s.final_sig", tag), 8'(o.sig), 8'(fin));
    chk($sformatf("%s.pass", tag), 8'(pass), 8'(gold == fin));
  endtask

  initial begin
    exp_t o;
    logic pass;
    pat_tab = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
    drive(1, 1'b0, 1'b0, 8'd0, 4'h0, 4'h0);
    drive(3, 1'b0, 1'b0, 8'd0, 4'h0, 4'h0);

    // Reset state
    #1 RSTN = 1'b0;
    #1;
    for (int s = 1; s <= 3; s += 2) begin
      sample(s, o, pass);
      chk("rst.pat", 8'(o.pat), 8'h1);
      chk("rst.pv", 8'(o.pv), 8'd0);
      chk("rst.busy", 8'(o.busy), 8'd0);
      chk("rst.done", 8'(o.done), 8'd0);
      chk("rst.sig", 8'(o.sig), 8'd0);
      chk("rst.pass", 8'(pass), 8'd0);
    end
    #1 RSTN = 1'b1;
    tick();

    // Full period of the 4-bit LFSR
    run(1, 15, 1, 4'h7, 4'h0, 0, "t1");

    // Known signature, PASS with right and wrong golden
    run(1, 4, 1, 4'h5, 4'h3, 0, "t2");
    chk("t2.sig3", 8'(b1.SIGNATURE), 8'h3);
    b1.GOLDEN = 4'h4;
    #1 chk("t2.pass_bad_gold", 8'(b1.PASS), 8'd0);
    b1.GOLDEN = 4'h3;
    #1 chk("t2.pass_good_gold", 8'(b1.PASS), 8'd1);

    // Zero patterns
    run(1, 0, 1, 4'h5, 4'h0, 0, "t3");

    // Longer CUT latency
    run(3, 2, 3, 4'h5, 4'hB, 0, "t4");

    // Abort in mid-run, then abort together with start
    drive(1, 1'b1, 1'b0, 8'd8, 4'h5, 4'h3);
    tick();
    drive(1, 1'b0, 1'b0, 8'd8, 4'h5, 4'h3);
    tick();
    tick();
    chk("t5.busy_before", 8'(b1.BUSY), 8'd1);
    chk("t5.sig_before", 8'(b1.SIGNATURE), 8'h5);
    drive(1, 1'b0, 1'b1, 8'd8, 4'h5, 4'h3);
    tick();
    drive(1, 1'b0, 1'b0, 8'd8, 4'h5, 4'h3);
    chk("t5.abort_busy", 8'(b1.BUSY), 8'd0);
    chk("t5.abort_pv", 8'(b1.PAT_VALID), 8'd0);
    chk("t5.abort_done", 8'(b1.DONE), 8'd0);
    chk("t5.abort_sig", 8'(b1.SIGNATURE), 8'd0);
    drive(1, 1'b1, 1'b1, 8'd4, 4'h5, 4'h3);
    tick();
    drive(1, 1'b0, 1'b0, 8'd4, 4'h5, 4'h3);
    chk("t5.abort_start_busy", 8'(b1.BUSY), 8'd0);
    chk("t5.abort_start_pv", 8'(b1.PAT_VALID), 8'd0);
    run(1, 4, 1, 4'h5, 4'h3, 0, "t5");

    // START while busy is ignored
    run(1, 4, 1, 4'h5, 4'h3, 2, "t6poke");

    // Asynchronous reset during drain
    drive(1, 1'b1, 1'b0, 8'd2, 4'h5, 4'h3);
    tick();
    drive(1, 1'b0, 1'b0, 8'd2, 4'h5, 4'h3);
    tick();
    tick();
    chk("t6.drain_busy", 8'(b1.BUSY), 8'd1);
    chk("t6.drain_pv", 8'(b1.PAT_VALID), 8'd0);
    #2 RSTN = 1'b0;
    #1;
    sample(1, o, pass);
    chk("t6.rst_pat", 8'(o.pat), 8'h1);
    chk("t6.rst_pv", 8'(o.pv), 8'd0);
    chk("t6.rst_busy", 8'(o.busy), 8'd0);
    chk("t6.rst_done", 8'(o.done), 8'd0);
    chk("t6.rst_sig", 8'(o.sig), 8'd0);
    chk("t6.rst_pass", 8'(pass), 8'd0);
    RSTN = 1'b1;
    tick();
    run(1, 4, 1, 4'h5, 4'h3, 0, "t6post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
